falafel_req_dispatcher: RTL and testbench
=========================================

// Module: falafel_req_dispatcher
//
// PURPOSE
// - Multi-channel front end of the allocator. Round-robin arbitrates NUM_CH request sources.
// - Each request is two beats: header, then payload. The header opcode steers the payload to
//   the config-register write port, the alloc FIFO or the free FIFO.
// - Illegal opcodes are counted and flagged, not asserted. A request is always drained, so a
//   channel never desynchronises.
// - Sits between the host/bus adapters and the alloc/free FIFOs plus config regs.
//
// PARAMETERS
// - DATA_W  64  beat width; header decodes as input_req_t / config_req_t
// - NUM_CH  2   request channels, >=1; CH_W = $clog2(NUM_CH) with a minimum of 1
// - ERR_W   16  width of the saturating illegal-opcode counter
//
// PORTS
// - clk_i               in   1               clock
// - rst_ni              in   1               async reset, active-low
// - req_val_i           in   NUM_CH          per-channel beat valid
// - req_rdy_o           out  NUM_CH          per-channel beat ready; at most one bit high
// - req_data_i          in   NUM_CH x DATA_W per-channel beat data
// - alloc_fifo_full_i   in   1               alloc FIFO full
// - alloc_fifo_write_o  out  1               alloc FIFO push
// - alloc_fifo_din_o    out  DATA_W          alloc FIFO data (payload of granted channel)
// - free_fifo_full_i    in   1               free FIFO full
// - free_fifo_write_o   out  1               free FIFO push
// - free_fifo_din_o     out  DATA_W          free FIFO data
// - cfg_write_o         out  1               config-register write strobe
// - cfg_addr_o          out  DATA_W          zero-extended config_req.addr of latched header
// - cfg_data_o          out  DATA_W          config write data (payload)
// - grant_o             out  CH_W            channel currently owning the dispatcher
// - busy_o              out  1               high whenever state != ARB
// - err_illegal_o       out  1               1-cycle pulse on illegal opcode decode
// - err_cnt_o           out  ERR_W           illegal-opcode count, saturates at all-ones
//
// BEHAVIOUR
// - Reset (async assert, sync release): state=ARB, rr_ptr=0, grant=0, header reg=0, err_cnt=0.
//   All write strobes, req_rdy_o, busy_o and err_illegal_o are 0.
//   A request partially transferred at reset is discarded.
// - ARB:
//   - Round-robin pick among asserted req_val_i, starting at rr_ptr.
//   - req_rdy_o[winner]=1 combinationally; the header beat is accepted in the same cycle.
//   - Latch header and grant, then go to DEC. No valid requests: stay in ARB.
// - DEC (1 cycle, no rdy):
//   - REQ_ACCESS_REGISTER -> CFG; REQ_ALLOC_MEM -> ALLOC; REQ_FREE_MEM -> FREE.
//   - Any other opcode -> DRAIN, with err_illegal_o=1 and err_cnt += 1 (saturating).
// - CFG: rdy=1. On handshake, cfg_write_o=1 in the same cycle and go to ARB.
// - ALLOC: rdy=!alloc_fifo_full_i. On handshake, alloc_fifo_write_o=1 in the same cycle, go to ARB.
// - FREE: rdy=!free_fifo_full_i. On handshake, free_fifo_write_o=1 in the same cycle, go to ARB.
// - DRAIN: rdy=1. Payload is consumed and discarded; no strobe; go to ARB.
// - On leaving CFG/ALLOC/FREE/DRAIN: rr_ptr = grant+1, wrapping NUM_CH-1 -> 0.
// - Latency: header in cycle t, payload accepted earliest t+2, FIFO/config write in the
//   payload cycle. Peak throughput is one request per 3 cycles.
// - The granted channel is locked from header through payload. Other channels see rdy=0.
// - FIFO full while in ALLOC/FREE: hold the state with rdy low. No timeout, no reordering.
// - Data outputs are muxed combinationally from req_data_i[grant]. They are don't-care while
//   the matching strobe is low.
// - Strobes are mutually exclusive; at most one asserts per cycle.
// - NUM_CH=1: the arbiter degenerates to pass-through and grant_o is tied to 0.
//
// STRUCTURE
// - falafel_pkg provides the existing opcode enum, input_req_t and config_req_t. Add
//   dispatch_state_e {ARB,DEC,CFG,ALLOC,FREE,DRAIN} to the package for TB visibility.
// - Sub-module falafel_rr_arbiter #(N):
//   - req_i[N], ptr_i, gnt_idx_o, gnt_val_o; purely combinational.
//   - The rotating pointer lives in the dispatcher.
//
// TESTING
// - Single request: ch0 header ALLOC then payload 0x40 -> alloc_fifo_write_o pulses once with
//   din 0x40, two cycles after the header handshake.
// - Contention: NUM_CH=2, both channels hold valid requests continuously -> grants alternate
//   0,1,0,1. Headers are accepted only in ARB, and rdy is never high on both channels.
// - Back-pressure: FREE request with free_fifo_full_i=1 for 5 cycles -> rdy low, no write.
//   On the cycle full drops, the payload is accepted and written exactly once.
// - Illegal opcode 3'b111 then payload -> err_illegal_o pulses once, err_cnt_o=1, no strobe.
//   The next legal request is dispatched correctly. Preload the counter at all-ones -> it stays
//   saturated.
// - Config: header REGISTER addr=0x8, payload 0xDEAD -> cfg_write_o=1,
//   cfg_addr_o=0x8, cfg_data_o=0xDEAD.
// - Reset mid-request: rst_ni low in DEC or ALLOC -> all outputs 0 immediately. After release,
//   state is ARB and grant_o=0, and the stale payload is not written.

Source files
------------

// File: rtl/falafel_pkg.sv
// falafel_pkg: request header layouts, opcodes and dispatcher state encoding
package falafel_pkg;

  typedef enum logic [2:0] {
    REQ_ACCESS_REGISTER = 3'd0,
    REQ_ALLOC_MEM       = 3'd1,
    REQ_FREE_MEM        = 3'd2
  } req_type_e;

  typedef struct packed {
    logic [60:0] rsvd;
    req_type_e   req_type;
  } input_req_t;

  typedef struct packed {
    logic [28:0] rsvd;
    logic [31:0] addr;
    req_type_e   req_type;
  } config_req_t;

  // Only opcode and config address of the header are ever consumed.
  localparam int HDR_USED_W = 35;

  typedef enum logic [2:0] {ARB, DEC, CFG, ALLOC, FREE, DRAIN} dispatch_state_e;

endpackage

// File: rtl/falafel_req_dispatcher_if.sv
// falafel_req_dispatcher_if: per-channel two-beat request valid/ready bus
interface falafel_req_dispatcher_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 64
);
  logic [NUM_CH-1:0]             req_val;
  logic [NUM_CH-1:0]             req_rdy;
  logic [NUM_CH-1:0][DATA_W-1:0] req_data;
  modport master (output req_val, output req_data, input req_rdy);
  modport slave  (input req_val, input req_data, output req_rdy);
endinterface

// File: rtl/falafel_rr_arbiter.sv
// falafel_rr_arbiter: combinational round-robin pick starting at ptr_i
module falafel_rr_arbiter #(
  parameter  int N  = 2,
  localparam int CW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [CW-1:0] ptr_i,
  output logic [CW-1:0] gnt_idx_o,
  output logic          gnt_val_o
);
  // scan from the farthest offset down so the requester nearest ptr_i wins
  always_comb begin
    gnt_val_o = |req_i;
    gnt_idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      gnt_idx_o = req_i[(int'(ptr_i) + i) % N] ? CW'((int'(ptr_i) + i) % N) : gnt_idx_o;
  end
endmodule

// File: rtl/falafel_req_dispatcher.sv
// falafel_req_dispatcher: arbitrates two-beat requests and steers payloads to cfg/alloc/free
module falafel_req_dispatcher
  import falafel_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int NUM_CH = 2,
  parameter  int ERR_W  = 16,
  localparam int CH_W   = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  falafel_req_dispatcher_if.slave req,
  input  logic                  alloc_fifo_full_i,
  output logic                  alloc_fifo_write_o,
  output logic [DATA_W-1:0]     alloc_fifo_din_o,
  input  logic                  free_fifo_full_i,
  output logic                  free_fifo_write_o,
  output logic [DATA_W-1:0]     free_fifo_din_o,
  output logic                  cfg_write_o,
  output logic [DATA_W-1:0]     cfg_addr_o,
  output logic [DATA_W-1:0]     cfg_data_o,
  output logic [CH_W-1:0]       grant_o,
  output logic                  busy_o,
  output logic                  err_illegal_o,
  output logic [ERR_W-1:0]      err_cnt_o
);

  dispatch_state_e       state_q, state_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d, grant_q, grant_d, arb_idx, next_ptr;
  logic [HDR_USED_W-1:0] header_q, header_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
  logic [NUM_CH-1:0]     rdy;
  logic [DATA_W-1:0]     sel_data;
  logic                  arb_val, sel_val;
  req_type_e             op;

  falafel_rr_arbiter #(.N(NUM_CH)) u_arb (
    .req_i     (req.req_val),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (arb_idx),
    .gnt_val_o (arb_val)
  );

  assign op        = req_type_e'(header_q[2:0]);
  assign sel_val   = req.req_val[grant_q];
  assign sel_data  = req.req_data[grant_q];
  assign next_ptr  = (32'(grant_q) == NUM_CH - 1) ? '0 : grant_q + 1'b1;
  assign req.req_rdy        = rdy;
  assign alloc_fifo_din_o   = sel_data;
  assign free_fifo_din_o    = sel_data;
  assign cfg_data_o         = sel_data;
  assign cfg_addr_o         = DATA_W'(header_q[34:3]);
  assign grant_o            = grant_q;
  assign busy_o             = state_q != ARB;
  assign err_cnt_o          = err_cnt_q;

  // next-state, handshake and strobe decode; ARB rdy is gated so nothing handshakes in reset
  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    grant_d            = grant_q;
    header_d           = header_q;
    err_cnt_d          = err_cnt_q;
    rdy                = '0;
    cfg_write_o        = 1'b0;
    alloc_fifo_write_o = 1'b0;
    free_fifo_write_o  = 1'b0;
    err_illegal_o      = 1'b0;
    case (state_q)
      ARB: if (arb_val && rst_ni) begin
        rdy[arb_idx] = 1'b1;
        header_d     = req.req_data[arb_idx][HDR_USED_W-1:0];
        grant_d      = arb_idx;
        state_d      = DEC;
      end
      DEC: begin
        state_d = op == REQ_ACCESS_REGISTER ? CFG :
                  op == REQ_ALLOC_MEM       ? ALLOC :
                  op == REQ_FREE_MEM        ? FREE : DRAIN;
        err_illegal_o = state_d == DRAIN;
        err_cnt_d     = (err_illegal_o && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
      end
      default: begin
        rdy[grant_q] = state_q == ALLOC ? !alloc_fifo_full_i :
                       state_q == FREE  ? !free_fifo_full_i : 1'b1;
        if (rdy[grant_q] && sel_val) begin
          cfg_write_o        = state_q == CFG;
          alloc_fifo_write_o = state_q == ALLOC;
          free_fifo_write_o  = state_q == FREE;
          rr_ptr_d           = next_ptr;
          state_d            = ARB;
        end
      end
    endcase
  end

  // state, arbitration pointer, latched header and error counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      header_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      header_q  <= header_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_falafel_req_dispatcher.sv
// tb_falafel_req_dispatcher: random two-channel traffic against a transaction-level model
module tb_falafel_req_dispatcher;
  import falafel_pkg::*;

  localparam int NCH = 2;
  localparam int DW  = 64;
  localparam int EW  = 3;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          afull, ffull, alloc_wr, free_wr, cfg_wr, busy, err_ill;
  logic [DW-1:0] alloc_din, free_din, cfg_addr, cfg_data;
  logic [0:0]    grant;
  logic [EW-1:0] err_cnt;

  falafel_req_dispatcher_if #(.NUM_CH(NCH), .DATA_W(DW)) rif();

  falafel_req_dispatcher #(.DATA_W(DW), .NUM_CH(NCH), .ERR_W(EW)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req                (rif),
    .alloc_fifo_full_i  (afull),
    .alloc_fifo_write_o (alloc_wr),
    .alloc_fifo_din_o   (alloc_din),
    .free_fifo_full_i   (ffull),
    .free_fifo_write_o  (free_wr),
    .free_fifo_din_o    (free_din),
    .cfg_write_o        (cfg_wr),
    .cfg_addr_o         (cfg_addr),
    .cfg_data_o         (cfg_data),
    .grant_o            (grant),
    .busy_o             (busy),
    .err_illegal_o      (err_ill),
    .err_cnt_o          (err_cnt)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: who owns the dispatcher, whether its header still awaits decode, and RR preference
  int          m_owner, m_next, m_grant, m_err;
  bit          m_dec;
  logic [2:0]  m_op;
  logic [31:0] m_addr;

  // per-channel stimulus: current request and which beat is being offered
  logic [63:0] hdr [NCH];
  logic [63:0] pay [NCH];
  bit          beat [NCH];

  logic [NCH-1:0] e_rdy;
  int             win;
  bit             e_fire, e_ill;

  function automatic logic [63:0] new_hdr();
    int          r = $urandom_range(0, 7);
    config_req_t c;
    c.rsvd     = 29'($urandom);
    c.addr     = $urandom;
    c.req_type = req_type_e'(r < 2 ? 3'd0 : r < 4 ? 3'd1 : r < 6 ? 3'd2 :
                             r == 6 ? 3'd7 : 3'($urandom_range(3, 7)));
    return c;
  endfunction

  task automatic new_req(input int c);
    hdr[c]  = new_hdr();
    pay[c]  = {$urandom, $urandom};
    beat[c] = 1'b0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_next  = 0;
    m_grant = 0;
    m_err   = 0;
    m_dec   = 1'b0;
    m_op    = '0;
    m_addr  = '0;
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      rif.req_data[c] = beat[c] ? pay[c] : hdr[c];
      rif.req_val[c]  = $urandom_range(0, 3) != 0;
    end
    afull = $urandom_range(0, 3) == 0;
    ffull = $urandom_range(0, 3) == 0;
  endtask

  // expected outputs for the current cycle from model state and current inputs
  task automatic evaluate();
    bit legal, r;
    e_rdy  = '0;
    e_fire = 1'b0;
    e_ill  = 1'b0;
    win    = -1;
    legal  = m_op <= 3'd2;
    if (m_owner < 0) begin
      for (int i = NCH - 1; i >= 0; i--)
        if (rif.req_val[(m_next + i) % NCH]) win = (m_next + i) % NCH;
      if (win >= 0) e_rdy[win] = 1'b1;
    end else if (m_dec) begin
      e_ill = !legal;
    end else begin
      r = !legal || m_op == 3'd0 || (m_op == 3'd1 && !afull) || (m_op == 3'd2 && !ffull);
      e_rdy[m_owner] = r;
      e_fire = r && rif.req_val[m_owner];
    end
    check("rdy", rif.req_rdy, e_rdy);
    check("alloc_wr", alloc_wr, e_fire && m_op == 3'd1);
    check("free_wr", free_wr, e_fire && m_op == 3'd2);
    check("cfg_wr", cfg_wr, e_fire && m_op == 3'd0);
    check("err_illegal", err_ill, e_ill);
    check("busy", busy, m_owner >= 0);
    check("grant", grant, m_grant);
    check("err_cnt", err_cnt, m_err);
    if (e_fire && m_op == 3'd1) check("alloc_din", alloc_din, pay[m_owner]);
    if (e_fire && m_op == 3'd2) check("free_din", free_din, pay[m_owner]);
    if (e_fire && m_op == 3'd0) begin
      check("cfg_addr", cfg_addr, {32'b0, m_addr});
      check("cfg_data", cfg_data, pay[m_owner]);
    end
  endtask

  // commit the cycle just clocked into the model, then move stimulus past accepted beats
  task automatic advance();
    if (m_owner < 0) begin
      if (win >= 0) begin
        m_owner = win;
        m_grant = win;
        m_op    = hdr[win][2:0];
        m_addr  = hdr[win][34:3];
        m_dec   = 1'b1;
      end
    end else if (m_dec) begin
      m_dec = 1'b0;
      if (e_ill) m_err = m_err == ERR_MAX ? ERR_MAX : m_err + 1;
    end else if (e_fire) begin
      m_next  = (m_owner + 1) % NCH;
      m_owner = -1;
    end
    for (int c = 0; c < NCH; c++)
      if (e_rdy[c] && rif.req_val[c]) begin
        if (beat[c]) new_req(c);
        else beat[c] = 1'b1;
      end
  endtask

  initial begin
    bit did_rst = 1'b0;
    model_reset();
    for (int c = 0; c < NCH; c++) new_req(c);
    for (int c = 0; c < NCH; c++) rif.req_data[c] = hdr[c];
    rif.req_val = '1;
    afull = 1'b0;
    ffull = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", rif.req_rdy, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_err_cnt", err_cnt, '0);
    check("rst_strobes", {alloc_wr, free_wr, cfg_wr, err_ill}, 4'b0);
    rst_n = 1'b1;
    #1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      evaluate();
      if (!did_rst && cyc > 2000 && m_owner >= 0) begin
        did_rst = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", rif.req_rdy, '0);
        check("mid_rst_strobes", {alloc_wr, free_wr, cfg_wr, err_ill}, 4'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_grant", grant, 1'b0);
        model_reset();
        for (int c = 0; c < NCH; c++) new_req(c);
        @(posedge clk);
        #1;
        drive();
        #1;
        check("in_rst_rdy", rif.req_rdy, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
      end else begin
        @(posedge clk);
        #1;
        advance();
        drive();
        @(negedge clk);
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
